res_collector: RTL and testbench

- Receive side of the stimulus/result path: accepts the per-cycle 8-bit result stream from the DUT wrapper and packs NUM results into a batch word.
- Hands each completed batch to the host-side DPI layer, the counterpart of the batch-in/item-out stimulus path.
- Double-buffered, so capture continues while the host drains the previous batch.
- Signals batch completion by a level handshake and by a toggle, mirroring the stimulus side's xmit_en.

---
 rtl/res_collector_pkg.sv | 24 ++
 rtl/res_bank.sv | 94 +++++++++
 rtl/res_collector.sv | 98 +++++++++
 tb/tb_res_collector.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : res_collector_pkg
// Description : Shared types and widths for the result collector: item type,
//               batch counter / checksum widths and the bank state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package res_collector_pkg;

    localparam int DEF_ITEM_WIDTH = 8;
    localparam int BATCH_CNT_W    = 16;
    localparam int SUM_W          = 16;

    typedef logic [DEF_ITEM_WIDTH-1:0] item_t;

    // Life cycle of one storage bank
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/res_bank.sv
`default_nettype none
// ============================================================================
// Module      : res_bank
// Description : One batch storage bank. Holds NUM items in arrival order,
//               its own write index and state (EMPTY/FILLING/FULL). With
//               RES_COLLECTOR_CHECKSUM_EN defined it also keeps a 16-bit
//               running sum of its items; otherwise o_sum is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module res_bank
    import res_collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      i_wr_en,
    input  logic [ITEM_WIDTH-1:0]     i_wr_data,
    input  logic                      i_drain,
    output logic                      o_full,
    output logic                      o_last,
    output logic [NUM*ITEM_WIDTH-1:0] o_data,
    output logic [SUM_W-1:0]          o_sum
);

    localparam int CNT_W = $clog2(NUM);

    logic [CNT_W-1:0] r_idx;
    bank_state_e      r_state;
    logic             w_write;
    logic             w_at_last;

    // A full bank refuses writes until it has been drained
    assign w_write   = i_wr_en && (r_state != FULL);
    assign w_at_last = (r_idx == CNT_W'(NUM - 1));
    assign o_full    = (r_state == FULL);
    assign o_last    = w_at_last;

    // Bank state machine and write index
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idx   <= '0;
            r_state <= EMPTY;
        end else if (w_write) begin
            if (w_at_last) begin
                r_idx   <= '0;
                r_state <= FULL;
            end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= FILLING;
            end
        end else if (i_drain && (r_state == FULL)) begin
            r_state <= EMPTY;
        end
    end

    for (genvar k = 0; k < NUM; k++) begin : g_item
        logic [ITEM_WIDTH-1:0] r_item;

        // Item slot k captures the k-th accepted item of the batch
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_item <= '0;
            end else if (w_write && (r_idx == CNT_W'(k))) begin
                r_item <= i_wr_data;
            end
        end

        assign o_data[k*ITEM_WIDTH +: ITEM_WIDTH] = r_item;
    end

`ifdef RES_COLLECTOR_CHECKSUM_EN
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_item_ext;

    assign w_item_ext = SUM_W'(i_wr_data);

    // Running sum restarts with the first item of every new batch
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sum <= '0;
        end else if (w_write) begin
            r_sum <= (r_idx == '0) ? w_item_ext : (r_sum + w_item_ext);
        end
    end

    assign o_sum = r_sum;
`else
    assign o_sum = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/res_collector.sv
`default_nettype none
// ============================================================================
// Module      : res_collector
// Description : Packs the per-cycle result stream into NUM-item batches using
//               two res_bank instances (ping-pong). Capture continues into one
//               bank while the host drains the other. Batch completion shows
//               on batch_valid_o (level), batch_toggle_o (toggle) and
//               batch_cnt_o. Optional checksum: RES_COLLECTOR_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module res_collector
    import res_collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      res_valid_i,
    input  logic [ITEM_WIDTH-1:0]     res_i,
    output logic                      res_ready_o,
    output logic                      batch_valid_o,
    output logic [NUM*ITEM_WIDTH-1:0] batch_data_o,
    input  logic                      batch_ready_i,
    output logic                      batch_toggle_o,
    output logic [BATCH_CNT_W-1:0]    batch_cnt_o,
    output logic [SUM_W-1:0]          batch_sum_o
);

    logic                      r_wr_bank;
    logic                      r_rd_bank;
    logic                      r_toggle;
    logic [BATCH_CNT_W-1:0]    r_cnt;

    logic [1:0]                w_full;
    logic [1:0]                w_last;
    logic [1:0]                w_wr_en;
    logic [1:0]                w_drain_bank;
    logic [NUM*ITEM_WIDTH-1:0] w_data [2];
    logic [SUM_W-1:0]          w_sum  [2];
    logic                      w_accept;
    logic                      w_drain;
    logic                      w_complete;

    assign res_ready_o   = !w_full[r_wr_bank];
    assign batch_valid_o = w_full[r_rd_bank];
    assign batch_data_o  = w_data[r_rd_bank];
    assign batch_sum_o   = w_sum[r_rd_bank];

    assign w_accept   = res_valid_i && res_ready_o;
    assign w_drain    = batch_valid_o && batch_ready_i;
    assign w_complete = w_accept && w_last[r_wr_bank];

    assign batch_toggle_o = r_toggle;
    assign batch_cnt_o    = r_cnt;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_wr_en[b]      = w_accept && (r_wr_bank == 1'(b));
        assign w_drain_bank[b] = w_drain  && (r_rd_bank == 1'(b));

        res_bank #(
            .NUM        (NUM),
            .ITEM_WIDTH (ITEM_WIDTH)
        ) u_bank (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .i_wr_en   (w_wr_en[b]),
            .i_wr_data (res_i),
            .i_drain   (w_drain_bank[b]),
            .o_full    (w_full[b]),
            .o_last    (w_last[b]),
            .o_data    (w_data[b]),
            .o_sum     (w_sum[b])
        );
    end

    // Bank selection and completion signalling; write and read sides move
    // independently so a completion and a drain in one cycle both take effect
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_toggle  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_complete) begin
                r_wr_bank <= ~r_wr_bank;
                r_toggle  <= ~r_toggle;
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_drain) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_res_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_res_collector
// Description : Self-checking bench for res_collector with NUM=4, 8-bit items.
//               Table of batch vectors plus hand-written corner sequences;
//               a scoreboard queue holds expected batches until drained.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_res_collector;
    import res_collector_pkg::*;

    localparam int NUM = 4;
    localparam int W   = 8;
    localparam int DW  = NUM * W;

    logic          clk;
    logic          rst;
    logic          res_valid;
    logic [W-1:0]  res;
    logic          res_ready;
    logic          batch_valid;
    logic [DW-1:0] batch_data;
    logic          batch_ready;
    logic          batch_toggle;
    logic [15:0]   batch_cnt;
    logic [15:0]   batch_sum;

    res_collector #(
        .NUM        (NUM),
        .ITEM_WIDTH (W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .res_valid_i    (res_valid),
        .res_i          (res),
        .res_ready_o    (res_ready),
        .batch_valid_o  (batch_valid),
        .batch_data_o   (batch_data),
        .batch_ready_i  (batch_ready),
        .batch_toggle_o (batch_toggle),
        .batch_cnt_o    (batch_cnt),
        .batch_sum_o    (batch_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // ---------------- scoreboard and reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [15:0]   sum;
    } batch_t;

    batch_t        sb[$];
    logic [DW-1:0] m_acc;
    logic [15:0]   m_sum;
    int            m_n;
    logic [15:0]   m_cnt;
    logic          m_tog;

    // Observe handshakes between edges: build expected batches, compare drains
    always @(negedge clk) begin
        batch_t e;
        if (rst) begin
            sb.delete();
            m_acc = '0;
            m_sum = '0;
            m_n   = 0;
            m_cnt = '0;
            m_tog = 1'b0;
        end else begin
            if (batch_valid && batch_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL drain_unexpected: got data %h expected no batch", batch_data);
                end else begin
                    e = sb.pop_front();
                    chk("drain_data", 64'(batch_data), 64'(e.data));
`ifdef RES_COLLECTOR_CHECKSUM_EN
                    chk("drain_sum", 64'(batch_sum), 64'(e.sum));
`endif
                end
            end
            if (res_valid && res_ready) begin
                m_acc[m_n*W +: W] = res;
                m_sum = m_sum + 16'(res);
                m_n++;
                if (m_n == NUM) begin
                    e.data = m_acc;
                    e.sum  = m_sum;
                    sb.push_back(e);
                    m_acc = '0;
                    m_sum = '0;
                    m_n   = 0;
                    m_cnt = m_cnt + 16'd1;
                    m_tog = ~m_tog;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        int n;
        n         = 0;
        res_valid = 1'b1;
        res       = v;
        while (!res_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) fail_now("send_stall");
        step();
        res_valid = 1'b0;
    endtask

    task automatic drain_pulse();
        batch_ready = 1'b1;
        step();
        batch_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0]  it [NUM];
        logic [DW-1:0] exp_data;
        logic [15:0]   exp_sum;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int drops;
        int n;

        tbl[0].it = '{8'h01, 8'h02, 8'h03, 8'h04};
        tbl[0].exp_data = 32'h04030201; tbl[0].exp_sum = 16'h000A;
        tbl[1].it = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[1].exp_data = 32'hFFFFFFFF; tbl[1].exp_sum = 16'h03FC;
        tbl[2].it = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].exp_data = 32'h00000000; tbl[2].exp_sum = 16'h0000;
        tbl[3].it = '{8'hA5, 8'h5A, 8'h0F, 8'hF0};
        tbl[3].exp_data = 32'hF00F5AA5; tbl[3].exp_sum = 16'h01FE;

        rst         = 1'b1;
        res_valid   = 1'b0;
        res         = '0;
        batch_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_ready",  64'(res_ready),    64'd1);
        chk("rst_valid",  64'(batch_valid),  64'd0);
        chk("rst_data",   64'(batch_data),   64'd0);
        chk("rst_toggle", 64'(batch_toggle), 64'd0);
        chk("rst_cnt",    64'(batch_cnt),    64'd0);
        chk("rst_sum",    64'(batch_sum),    64'd0);

        // First batch, host idle
        send(8'h11); send(8'h22); send(8'h33);
        chk("t1_valid_early", 64'(batch_valid), 64'd0);
        send(8'h44);
        chk("t1_valid",  64'(batch_valid),  64'd1);
        chk("t1_data",   64'(batch_data),   64'h44332211);
        chk("t1_toggle", 64'(batch_toggle), 64'd1);
        chk("t1_cnt",    64'(batch_cnt),    64'd1);
`ifdef RES_COLLECTOR_CHECKSUM_EN
        chk("t1_sum",    64'(batch_sum),    64'h00AA);
`endif
        drain_pulse();
        chk("t1_drained", 64'(batch_valid), 64'd0);

        // Table-driven batches, each drained before the next
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NUM; j++) send(tbl[i].it[j]);
            chk("tbl_valid", 64'(batch_valid), 64'd1);
            chk("tbl_data",  64'(batch_data),  64'(tbl[i].exp_data));
`ifdef RES_COLLECTOR_CHECKSUM_EN
            chk("tbl_sum",   64'(batch_sum),   64'(tbl[i].exp_sum));
`else
            chk("tbl_sum0",  64'(batch_sum),   64'd0);
`endif
            drain_pulse();
            chk("tbl_drained", 64'(batch_valid), 64'd0);
        end
        chk("tbl_cnt",    64'(batch_cnt),    64'(m_cnt));
        chk("tbl_toggle", 64'(batch_toggle), 64'(m_tog));

        // Both banks full, stall, single drain releases the stalled item
        for (int i = 1; i <= 8; i++) send(W'(i));
        chk("t2_ready_low", 64'(res_ready),  64'd0);
        chk("t2_valid",     64'(batch_valid), 64'd1);
        chk("t2_data0",     64'(batch_data),  64'h04030201);
        res_valid = 1'b1;
        res       = 8'h09;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall", 64'(res_ready), 64'd0);
        end
        batch_ready = 1'b1;
        step();
        batch_ready = 1'b0;
        chk("t2_data1",  64'(batch_data),  64'h08070605);
        chk("t2_valid1", 64'(batch_valid), 64'd1);
        chk("t2_ready",  64'(res_ready),   64'd1);
        step();
        res_valid = 1'b0;
        send(8'h0A); send(8'h0B); send(8'h0C);
        drain_pulse();
        drain_pulse();
        chk("t2_empty", 64'(batch_valid), 64'd0);

        // Continuous stream with host always ready
        do_reset();
        batch_ready = 1'b1;
        drops       = 0;
        res_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            res = W'(i * 7 + 3);
            if (!res_ready) drops++;
            step();
        end
        res_valid = 1'b0;
        n = 0;
        while ((sb.size() != 0 || batch_valid) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail_now("t3_flush");
        batch_ready = 1'b0;
        chk("t3_drops",  64'(drops),        64'd0);
        chk("t3_cnt",    64'(batch_cnt),    64'd10);
        chk("t3_toggle", 64'(batch_toggle), 64'd0);

        // Last item of bank 1 accepted in the same cycle bank 0 drains
        send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
        send(8'hC0); send(8'hC1); send(8'hC2);
        chk("t4_ready", 64'(res_ready), 64'd1);
        res_valid   = 1'b1;
        res         = 8'hC3;
        batch_ready = 1'b1;
        step();
        res_valid   = 1'b0;
        batch_ready = 1'b0;
        chk("t4_valid", 64'(batch_valid), 64'd1);
        chk("t4_data",  64'(batch_data),  64'hC3C2C1C0);
        chk("t4_cnt",   64'(batch_cnt),   64'd12);
        drain_pulse();
        chk("t4_empty", 64'(batch_valid), 64'd0);

        // Reset in the middle of a batch
        send(8'h55); send(8'h66);
        do_reset();
        chk("t5_cnt0",  64'(batch_cnt),   64'd0);
        chk("t5_valid0", 64'(batch_valid), 64'd0);
        send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
        chk("t5_valid", 64'(batch_valid), 64'd1);
        chk("t5_data",  64'(batch_data),  64'hA3A2A1A0);
        chk("t5_cnt",   64'(batch_cnt),   64'd1);
        drain_pulse();

        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
